// File: rtl/dense_layer_sequencer_if.sv
// Bus bundle for the dense layer sequencer: control handshake, ROM/buffer read ports and
// the per-neuron result write port. The sequencer drives through the master modport.
interface dense_layer_sequencer_if #(
   parameter int unsigned NUM_INPUTS  = 10,
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned DATA_WIDTH  = 16
);
   localparam int unsigned IAW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int unsigned WAW = (NUM_INPUTS * NUM_NEURONS > 1) ?
                                 $clog2(NUM_INPUTS * NUM_NEURONS) : 1;
   localparam int unsigned BAW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

   logic                  start;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic [IAW-1:0]        input_addr;
   logic [DATA_WIDTH-1:0] input_data;
   logic [WAW-1:0]        weight_addr;
   logic [DATA_WIDTH-1:0] weight_data;
   logic [BAW-1:0]        bias_addr;
   logic [DATA_WIDTH-1:0] bias_data;
   logic                  out_valid;
   logic [BAW-1:0]        out_addr;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      input  start, abort, input_data, weight_data, bias_data,
      output busy, done, input_addr, weight_addr, bias_addr, out_valid, out_addr, out_data
   );

   modport slave (
      output start, abort, input_data, weight_data, bias_data,
      input  busy, done, input_addr, weight_addr, bias_addr, out_valid, out_addr, out_data
   );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Time-multiplexed dense layer controller: walks every (neuron, input) pair through one MAC,
// then writes one biased, saturated and activated fixed-point result per neuron.
module dense_layer_sequencer #(
   parameter int unsigned NUM_INPUTS  = 10,
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned FRAC_BITS   = 8,
   parameter int unsigned ACTIVATION  = 1
) (
   input logic                     clock,
   input logic                     reset_n,
   dense_layer_sequencer_if.master bus
);
   localparam int unsigned IAW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int unsigned WAW  = (NUM_INPUTS * NUM_NEURONS > 1) ?
                                  $clog2(NUM_INPUTS * NUM_NEURONS) : 1;
   localparam int unsigned BAW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int unsigned DW   = DATA_WIDTH;
   localparam int unsigned ACCW = 2 * DW + $clog2(NUM_INPUTS + 1);
   localparam int unsigned SUMW = ACCW + 1;

   localparam logic [IAW-1:0] LAST_IDX = IAW'(NUM_INPUTS - 1);
   localparam logic [BAW-1:0] LAST_NEURON = BAW'(NUM_NEURONS - 1);
   localparam logic signed [SUMW-1:0] SAT_MAX = {{(SUMW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SUMW-1:0] SAT_MIN = {{(SUMW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StAccum, StDrain, StWrite, StDone} state_e;

   state_e                 state_q, state_d;
   logic [IAW-1:0]         idx_q, idx_d;
   logic [BAW-1:0]         neuron_q, neuron_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic signed [DW-1:0]   bias_q, bias_d;
   logic                   pipe_q, pipe_d;
   logic                   bias_ld_q, bias_ld_d;

   logic signed [2*DW-1:0] prod_w;
   logic signed [ACCW-1:0] shifted_w;
   logic signed [SUMW-1:0] sum_w;
   logic signed [DW-1:0]   sat_w;

   assign prod_w = $signed({{DW{bus.input_data[DW-1]}}, bus.input_data}) *
                   $signed({{DW{bus.weight_data[DW-1]}}, bus.weight_data});

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      neuron_d  = neuron_q;
      acc_d     = acc_q;
      bias_d    = bias_q;
      pipe_d    = 1'b0;
      bias_ld_d = 1'b0;

      if (pipe_q) acc_d = acc_q + ACCW'(prod_w);
      if (bias_ld_q) bias_d = $signed(bus.bias_data);

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d  = StAccum;
               idx_d    = '0;
               neuron_d = '0;
               acc_d    = '0;
            end
         end
         StAccum: begin
            pipe_d    = 1'b1;
            // pipe_q is low only on the first ACCUM cycle of a neuron
            bias_ld_d = ~pipe_q;
            if (idx_q == LAST_IDX) state_d = StDrain;
            else                   idx_d   = idx_q + 1'b1;
         end
         StDrain: state_d = StWrite;
         StWrite: begin
            if (neuron_q == LAST_NEURON) begin
               state_d = StDone;
            end else begin
               state_d  = StAccum;
               neuron_d = neuron_q + 1'b1;
               idx_d    = '0;
               acc_d    = '0;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (bus.abort && (state_q != StIdle)) begin
         state_d   = StIdle;
         idx_d     = '0;
         neuron_d  = '0;
         acc_d     = '0;
         pipe_d    = 1'b0;
         bias_ld_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         neuron_q  <= '0;
         acc_q     <= '0;
         bias_q    <= '0;
         pipe_q    <= 1'b0;
         bias_ld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         neuron_q  <= neuron_d;
         acc_q     <= acc_d;
         bias_q    <= bias_d;
         pipe_q    <= pipe_d;
         bias_ld_q <= bias_ld_d;
      end
   end

   // Floor-rounded rescale, bias add, then clamp to the signed DATA_WIDTH range
   always_comb begin
      shifted_w = acc_q >>> FRAC_BITS;
      sum_w     = SUMW'(shifted_w) + SUMW'(bias_q);
      if (sum_w > SAT_MAX)      sat_w = {1'b0, {(DW-1){1'b1}}};
      else if (sum_w < SAT_MIN) sat_w = {1'b1, {(DW-1){1'b0}}};
      else                      sat_w = sum_w[DW-1:0];
   end

   assign bus.out_data    = ((ACTIVATION == 1) && sat_w[DW-1]) ? '0 : sat_w;
   assign bus.busy        = (state_q != StIdle);
   assign bus.done        = (state_q == StDone);
   assign bus.out_valid   = (state_q == StWrite);
   assign bus.out_addr    = neuron_q;
   assign bus.bias_addr   = neuron_q;
   assign bus.input_addr  = idx_q;
   assign bus.weight_addr = WAW'(32'(neuron_q) * NUM_INPUTS + 32'(idx_q));
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Scoreboard bench: a RELU and a linear instance see identical stimulus; expected writes are
// queued per instance when a pass is launched and popped by a monitor on each out_valid.
module tb_dense_layer_sequencer;
   localparam int unsigned NI = 3;
   localparam int unsigned NN = 2;
   localparam int unsigned DW = 16;

   typedef struct {
      logic [0:0]    addr;
      logic [DW-1:0] data;
   } exp_t;

   logic clock;
   logic reset_n;
   int   checks;
   int   failures;
   exp_t q_r[$];
   exp_t q_n[$];

   logic [DW-1:0] in_mem [NI];
   logic [DW-1:0] w_mem  [NI*NN];
   logic [DW-1:0] b_mem  [NN];

   dense_layer_sequencer_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) ifr ();
   dense_layer_sequencer_if #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) ifn ();

   dense_layer_sequencer #(
      .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .FRAC_BITS(8), .ACTIVATION(1)
   ) dut_r (
      .clock(clock), .reset_n(reset_n), .bus(ifr)
   );

   dense_layer_sequencer #(
      .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .FRAC_BITS(8), .ACTIVATION(0)
   ) dut_n (
      .clock(clock), .reset_n(reset_n), .bus(ifn)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Buffers/ROMs with one-cycle read latency
   always @(posedge clock) begin
      ifr.input_data  <= in_mem[int'(ifr.input_addr)];
      ifr.weight_data <= w_mem[int'(ifr.weight_addr)];
      ifr.bias_data   <= b_mem[int'(ifr.bias_addr)];
      ifn.input_data  <= in_mem[int'(ifn.input_addr)];
      ifn.weight_data <= w_mem[int'(ifn.weight_addr)];
      ifn.bias_data   <= b_mem[int'(ifn.bias_addr)];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (ifr.out_valid) begin
            if (q_r.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL relu_unexpected_write: got addr 0x%0h data 0x%0h expected none",
                        ifr.out_addr, ifr.out_data);
            end else begin
               exp_t e;
               e = q_r.pop_front();
               check("relu_out_addr", 32'(ifr.out_addr), 32'(e.addr));
               check("relu_out_data", 32'(ifr.out_data), 32'(e.data));
            end
         end
         if (ifn.out_valid) begin
            if (q_n.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL lin_unexpected_write: got addr 0x%0h data 0x%0h expected none",
                        ifn.out_addr, ifn.out_data);
            end else begin
               exp_t e;
               e = q_n.pop_front();
               check("lin_out_addr", 32'(ifn.out_addr), 32'(e.addr));
               check("lin_out_data", 32'(ifn.out_data), 32'(e.data));
            end
         end
         check("valid_done_exclusive", 32'(ifr.out_valid & ifr.done), 32'd0);
      end
   end

   task automatic drive(input logic s, input logic a);
      ifr.start = s;
      ifn.start = s;
      ifr.abort = a;
      ifn.abort = a;
   endtask

   task automatic push_exp(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                           input logic [DW-1:0] n0, input logic [DW-1:0] n1, input bit both);
      q_r.push_back('{1'b0, r0});
      q_n.push_back('{1'b0, n0});
      if (both) begin
         q_r.push_back('{1'b1, r1});
         q_n.push_back('{1'b1, n1});
      end
   endtask

   task automatic load(input int sel);
      case (sel)
         0: begin // unit weights / negated weights
            in_mem = '{16'h0100, 16'h0200, 16'h0300};
            w_mem  = '{16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'hFF00};
            b_mem  = '{16'h0080, 16'h0000};
         end
         1: begin // saturation both ways
            in_mem = '{16'h6400, 16'h6400, 16'h6400};
            w_mem  = '{16'h6400, 16'h6400, 16'h6400, 16'h9C00, 16'h9C00, 16'h9C00};
            b_mem  = '{16'h0000, 16'h0000};
         end
         default: begin // mixed signs, negative bias, floor rounding of -1.5 LSB
            in_mem = '{16'h0180, 16'hFF80, 16'h0001};
            w_mem  = '{16'h0100, 16'h0100, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
            b_mem  = '{16'hFFC0, 16'h0000};
         end
      endcase
   endtask

   // Leaves the caller half a cycle after the edge that sampled start (cycle k=0)
   task automatic pulse_start();
      @(negedge clock);
      drive(1'b1, 1'b0);
      @(negedge clock);
      drive(1'b0, 1'b0);
   endtask

   task automatic run_pass(input bit glitch);
      pulse_start();
      for (int k = 0; k <= int'(NN * (NI + 2)) + 1; k++) begin
         int n;
         int p;
         n = k / int'(NI + 2);
         p = k % int'(NI + 2);
         if (k < int'(NN * (NI + 2))) begin
            check("busy", 32'(ifr.busy), 32'd1);
            check("done_early", 32'(ifr.done), 32'd0);
            check("out_valid", 32'(ifr.out_valid), 32'(p == int'(NI + 1)));
            if (p < int'(NI)) begin
               check("input_addr", 32'(ifr.input_addr), 32'(p));
               check("weight_addr", 32'(ifr.weight_addr), 32'(n * int'(NI) + p));
               check("bias_addr", 32'(ifr.bias_addr), 32'(n));
            end
            if (p == int'(NI + 1)) check("write_addr", 32'(ifr.out_addr), 32'(n));
         end else if (k == int'(NN * (NI + 2))) begin
            check("done", 32'(ifr.done), 32'd1);
            check("lin_done", 32'(ifn.done), 32'd1);
            check("busy_at_done", 32'(ifr.busy), 32'd1);
         end else begin
            check("busy_after_done", 32'(ifr.busy), 32'd0);
            check("done_one_cycle", 32'(ifr.done), 32'd0);
         end
         drive(glitch && (k == 2), 1'b0);
         @(negedge clock);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b1;
      drive(1'b0, 1'b0);
      load(0);
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_busy", 32'(ifr.busy), 32'd0);
      check("rst_done", 32'(ifr.done), 32'd0);
      check("rst_out_valid", 32'(ifr.out_valid), 32'd0);
      check("rst_input_addr", 32'(ifr.input_addr), 32'd0);
      check("rst_weight_addr", 32'(ifr.weight_addr), 32'd0);
      check("rst_bias_addr", 32'(ifr.bias_addr), 32'd0);
      check("rst_out_addr", 32'(ifr.out_addr), 32'd0);
      check("rst_out_data", 32'(ifr.out_data), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      push_exp(16'h0680, 16'h0000, 16'h0680, 16'hFA00, 1'b1);
      run_pass(1'b0);

      load(2);
      push_exp(16'h00C0, 16'h0000, 16'h00C0, 16'hFFFE, 1'b1);
      run_pass(1'b1);

      load(1);
      push_exp(16'h7FFF, 16'h0000, 16'h7FFF, 16'h8000, 1'b1);
      run_pass(1'b0);

      // Abort in neuron 1 ACCUM: only neuron 0 is written, no done afterwards
      load(0);
      push_exp(16'h0680, 16'h0000, 16'h0680, 16'h0000, 1'b0);
      pulse_start();
      repeat (int'(NI + 2) + 1) @(negedge clock);
      drive(1'b0, 1'b1);
      @(negedge clock);
      drive(1'b0, 1'b0);
      check("abort_busy", 32'(ifr.busy), 32'd0);
      check("abort_lin_busy", 32'(ifn.busy), 32'd0);
      for (int i = 0; i < 12; i++) begin
         check("abort_no_done", 32'(ifr.done | ifn.done), 32'd0);
         @(negedge clock);
      end
      push_exp(16'h0680, 16'h0000, 16'h0680, 16'hFA00, 1'b1);
      run_pass(1'b0);

      // Asynchronous reset in the middle of the neuron 0 WRITE cycle
      push_exp(16'h0680, 16'h0000, 16'h0680, 16'h0000, 1'b0);
      pulse_start();
      repeat (int'(NI + 1)) @(negedge clock);
      check("pre_rst_out_valid", 32'(ifr.out_valid), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      check("async_out_valid", 32'(ifr.out_valid), 32'd0);
      check("async_busy", 32'(ifr.busy), 32'd0);
      check("async_done", 32'(ifr.done), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("post_rst_busy", 32'(ifr.busy), 32'd0);
      check("post_rst_weight_addr", 32'(ifr.weight_addr), 32'd0);
      push_exp(16'h0680, 16'h0000, 16'h0680, 16'hFA00, 1'b1);
      run_pass(1'b0);

      @(negedge clock);
      check("relu_queue_empty", 32'(q_r.size()), 32'd0);
      check("lin_queue_empty", 32'(q_n.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dense_layer_sequencer.md
Name: dense_layer_sequencer

Overview:
Time-multiplexed controller for one dense layer of the network. It drives a single shared multiply-accumulate path over every (neuron, input) pair. It generates read addresses into the layer's input buffer, weight ROM and bias ROM, then writes one activated fixed_point result per neuron. It sits between the input buffer and the next layer, under the top-level classifier state machine's start/done handshake.

Parameters:
NUM_INPUTS, 10, inputs per neuron (>=1)
NUM_NEURONS, 16, neurons in the layer (>=1)
DATA_WIDTH, 16, fixed_point width, two's complement
FRAC_BITS, 8, fractional bits of fixed_point
ACTIVATION, 1, 0 = NONE, 1 = RELU

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  begin a layer pass; sampled only in IDLE
abort  in  1  synchronous cancel of a pass in progress
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last neuron is written
input_addr  out  clog2(NUM_INPUTS)  input buffer read index
input_data  in  DATA_WIDTH  valid one cycle after input_addr
weight_addr  out  clog2(NUM_INPUTS*NUM_NEURONS)  equals neuron*NUM_INPUTS + input index
weight_data  in  DATA_WIDTH  valid one cycle after weight_addr
bias_addr  out  clog2(NUM_NEURONS)  equals current neuron index
bias_data  in  DATA_WIDTH  valid one cycle after bias_addr
out_valid  out  1  write strobe, one cycle per neuron
out_addr  out  clog2(NUM_NEURONS)  neuron index of out_data
out_data  out  DATA_WIDTH  activated result

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE. busy, done, out_valid=0. All addresses, out_data, accumulator and counters = 0.
- States: IDLE, ACCUM, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 -> ACCUM; neuron=0, idx=0, acc=0.
  - start while not in IDLE is ignored.
- ACCUM:
  - Each cycle present input_addr=idx, weight_addr=neuron*NUM_INPUTS+idx, bias_addr=neuron.
  - A 1-bit pipe flag marks data returning next cycle. When the flag is set, acc += input_data*weight_data, using the full 2*DATA_WIDTH product.
  - bias_data is latched on the cycle after ACCUM entry.
  - idx increments each cycle. After idx=NUM_INPUTS-1 is issued -> DRAIN.
- DRAIN: one cycle; the last product is accumulated -> WRITE.
- WRITE:
  - out_valid=1, out_addr=neuron.
  - out_data = activation(sat((acc >>> FRAC_BITS) + sign-extended bias)).
  - Shift is arithmetic, floor rounding.
  - sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - RELU maps negative results to 0.
  - If neuron=NUM_NEURONS-1 -> DONE. Otherwise neuron++, idx=0, acc=0 -> ACCUM.
- DONE: done=1 for one cycle -> IDLE.
- Accumulator width: 2*DATA_WIDTH + clog2(NUM_INPUTS+1); it must never overflow.
- Timing:
  - Each neuron costs NUM_INPUTS+2 cycles.
  - If start is sampled at edge t, done is high in cycle t+1+NUM_NEURONS*(NUM_INPUTS+2).
  - busy rises the cycle after start and falls the cycle after done.
- abort=1 in any busy state:
  - Next state is IDLE; acc and counters are cleared.
  - No further out_valid pulses and no done.
  - If abort coincides with WRITE, that write still occurs but done is suppressed.
- Addresses hold their last value in IDLE.
- NUM_INPUTS=1: ACCUM lasts exactly one cycle.
- out_valid and done are never high in the same cycle.

Test Plan:
1. NUM_INPUTS=3, NUM_NEURONS=2, RELU, 1.0=0x0100. Inputs {1.0,2.0,3.0}, n0 weights {1,1,1}, bias 0.5; n1 weights {-1,-1,-1}, bias 0 -> out[0]=0x0680, out[1]=0x0000. done 11 cycles after start edge.
2. Same stimulus with ACTIVATION=0 -> out[1]=0xFA00 (-6.0).
3. Address trace -> weight_addr 0,1,2,3,4,5; input_addr 0,1,2,0,1,2; out_addr 0 then 1; each out_valid exactly one cycle.
4. Saturation: all inputs 0x6400, weights 0x6400 -> out_data=0x7FFF. Inputs 0x6400, weights 0x9C00 with ACTIVATION=0 -> 0x8000.
5. abort during neuron 1 ACCUM -> only out_addr 0 written, no done, busy low next cycle. A following start re-runs from neuron 0 with identical results.
6. start pulsed while busy -> no effect, total cycles unchanged. reset_n low mid-WRITE -> out_valid, busy and done drop to 0 immediately (asynchronously); state IDLE after release.
